// File: rtl/dispense_pkg.sv
// Shared types for the dispense controller: command codes, FSM states and
// the queue-level width helper.
package dispense_pkg;

  typedef enum logic [1:0] {
    CMD_VEND = 2'd0,
    CMD_C10  = 2'd1,
    CMD_C5   = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRIVE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Push slot i carries the command with that capture priority.
  function automatic logic [1:0] push_cmd(input int idx);
    case (idx)
      0:       return CMD_VEND;
      1:       return CMD_C10;
      default: return CMD_C5;
    endcase
  endfunction

endpackage

// File: rtl/dispense_cmd_fifo.sv
// Command queue: up to three ordered pushes per cycle limited by the room at
// the start of the cycle, one pop, and a drop flag for refused pushes.
module dispense_cmd_fifo
  import dispense_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int LW     = lvl_w(QDEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    wr_req,
  input  logic          rd_en,
  output logic [1:0]    rd_data,
  output logic [LW-1:0] level,
  output logic [LW-1:0] level_next,
  output logic          empty,
  output logic          drop
);

  localparam int AW = $clog2(QDEPTH);

  logic [1:0]    mem_q [QDEPTH];
  logic [1:0]    mem_d [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] room;
  logic [LW-1:0] n_acc;
  logic          rd_fire;

  always_comb begin
    mem_d   = mem_q;
    n_acc   = '0;
    drop    = 1'b0;
    room    = LW'(QDEPTH) - level_q;
    for (int i = 0; i < 3; i++) begin
      if (wr_req[i]) begin
        if (n_acc < room) begin
          mem_d[wr_ptr_q + n_acc[AW-1:0]] = push_cmd(i);
          n_acc = n_acc + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    rd_fire  = rd_en && (level_q != '0);
    wr_ptr_d = wr_ptr_q + n_acc[AW-1:0];
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    level_d  = level_q + n_acc - LW'(rd_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign level_next = level_d;
  assign empty      = (level_q == '0);

endmodule

// File: rtl/dispense_controller.sv
// Drives the item motor and coin solenoids one command at a time from the
// queue, with vend-done handshake, timeout fault and sticky overflow.
module dispense_controller
  import dispense_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int QDEPTH         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vend_in,
  input  logic                    change_5c_in,
  input  logic                    change_10c_in,
  input  logic                    vend_done,
  input  logic                    fault_clr,
  output logic                    vend_motor,
  output logic                    coin5_sol,
  output logic                    coin10_sol,
  output logic                    busy,
  output logic [$clog2(QDEPTH):0] q_level,
  output logic                    overflow,
  output logic                    fault
);

  localparam int LW = lvl_w(QDEPTH);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          done_seen_q, done_seen_d;
  logic          fault_q, fault_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;
  logic [2:0]    act_q, act_d;
  logic          fault_set;
  logic          pop;
  logic [1:0]    head;
  logic [LW-1:0] level, level_next;
  logic          empty, drop;

  dispense_cmd_fifo #(.QDEPTH(QDEPTH), .LW(LW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_req     ({change_5c_in, change_10c_in, vend_in}),
    .rd_en      (pop),
    .rd_data    (head),
    .level      (level),
    .level_next (level_next),
    .empty      (empty),
    .drop       (drop)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    pulse_cnt_d = pulse_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    done_seen_d = done_seen_q;
    fault_set   = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !fault_q) begin
          pop         = 1'b1;
          cmd_d       = cmd_e'(head);
          pulse_cnt_d = PW'(PULSE_CYCLES);
          done_seen_d = 1'b0;
          state_d     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cmd_q == CMD_VEND && vend_done) done_seen_d = 1'b1;
        if (pulse_cnt_q == PW'(1)) begin
          // An early drop sensor pulse during the motor drive skips the wait.
          if (cmd_q == CMD_VEND && !(done_seen_q || vend_done)) begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT_DONE;
          end else begin
            gap_cnt_d = GW'(GAP_CYCLES);
            state_d   = ST_GAP;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q - 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (vend_done) begin
          gap_cnt_d = GW'(GAP_CYCLES);
          state_d   = ST_GAP;
        end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fault_set = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(1)) state_d = ST_IDLE;
        else                     gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    fault_d    = fault_clr ? 1'b0 : (fault_q | fault_set);
    overflow_d = fault_clr ? 1'b0 : (overflow_q | drop);
    busy_d     = (state_d != ST_IDLE) || (level_next != '0);
    act_d      = 3'b000;
    if (state_q == ST_DRIVE) begin
      case (cmd_q)
        CMD_VEND: act_d = 3'b001;
        CMD_C10:  act_d = 3'b010;
        CMD_C5:   act_d = 3'b100;
        default:  act_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_VEND;
      pulse_cnt_q <= '0;
      gap_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      done_seen_q <= 1'b0;
      fault_q     <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      act_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      pulse_cnt_q <= pulse_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      done_seen_q <= done_seen_d;
      fault_q     <= fault_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      act_q       <= act_d;
    end
  end

  assign vend_motor = act_q[0];
  assign coin10_sol = act_q[1];
  assign coin5_sol  = act_q[2];
  assign busy       = busy_q;
  assign q_level    = level;
  assign overflow   = overflow_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_dispense_controller.sv
// Directed bench for dispense_controller: timing of actuator pulses relative
// to the capturing edge, handshake, timeout fault, overflow and reset.
module tb_dispense_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vend_in = 1'b0;
  logic       change_5c_in = 1'b0;
  logic       change_10c_in = 1'b0;
  logic       vend_done = 1'b0;
  logic       fault_clr = 1'b0;
  logic       vend_motor, coin5_sol, coin10_sol, busy, overflow, fault;
  logic [2:0] q_level;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c0 = 0;
  int rise [3];
  int fall [3];
  int busy_fall;
  int fault_rise;
  int overlap;
  logic [2:0] prev_act;
  logic       prev_busy;
  logic       prev_fault;

  always #5 clk = ~clk;

  dispense_controller dut (
    .clk           (clk),
    .rst           (rst),
    .vend_in       (vend_in),
    .change_5c_in  (change_5c_in),
    .change_10c_in (change_10c_in),
    .vend_done     (vend_done),
    .fault_clr     (fault_clr),
    .vend_motor    (vend_motor),
    .coin5_sol     (coin5_sol),
    .coin10_sol    (coin10_sol),
    .busy          (busy),
    .q_level       (q_level),
    .overflow      (overflow),
    .fault         (fault)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Pulse the given inputs so they are sampled on the next edge; that edge is E0.
  task automatic pulse_in(input logic v, input logic c10, input logic c5);
    vend_in = v; change_10c_in = c10; change_5c_in = c5;
    tick();
    vend_in = 1'b0; change_10c_in = 1'b0; change_5c_in = 1'b0;
    c0 = cyc;
  endtask

  task automatic clear_rec();
    for (int i = 0; i < 3; i++) begin
      rise[i] = -1;
      fall[i] = -1;
    end
    busy_fall  = -1;
    fault_rise = -1;
    overlap    = 0;
    prev_act   = {coin5_sol, coin10_sol, vend_motor};
    prev_busy  = busy;
    prev_fault = fault;
  endtask

  // Step n cycles, recording first edges relative to c0; vend_done is
  // sampled on edge E(done_k+1) when done_k >= 0.
  task automatic watch(input int n, input int done_k);
    logic [2:0] a;
    int k;
    for (int j = 0; j < n; j++) begin
      tick();
      k = cyc - c0;
      a = {coin5_sol, coin10_sol, vend_motor};
      for (int i = 0; i < 3; i++) begin
        if (a[i] && !prev_act[i] && rise[i] < 0) rise[i] = k;
        if (!a[i] && prev_act[i] && fall[i] < 0) fall[i] = k;
      end
      if ($countones(a) > 1) overlap++;
      if (!busy && prev_busy && busy_fall < 0) busy_fall = k;
      if (fault && !prev_fault && fault_rise < 0) fault_rise = k;
      prev_act   = a;
      prev_busy  = busy;
      prev_fault = fault;
      vend_done  = (k == done_k);
    end
    vend_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_motor", int'(vend_motor), 0);
    check("rst_c5", int'(coin5_sol), 0);
    check("rst_c10", int'(coin10_sol), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_qlevel", int'(q_level), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_fault", int'(fault), 0);

    // Single 10c refund.
    clear_rec();
    pulse_in(1'b0, 1'b1, 1'b0);
    check("c10_qlevel_push", int'(q_level), 1);
    check("c10_busy", int'(busy), 1);
    watch(12, -1);
    check("c10_rise", rise[1], 2);
    check("c10_fall", fall[1], 6);
    check("c10_busy_fall", busy_fall, 7);
    check("c10_qlevel_end", int'(q_level), 0);
    check("c10_no_motor", rise[0], -1);

    // Overpay: vend then 5c, done three cycles after the motor falls.
    clear_rec();
    pulse_in(1'b1, 1'b0, 1'b1);
    check("ovp_qlevel", int'(q_level), 2);
    watch(24, 8);
    check("ovp_motor_rise", rise[0], 2);
    check("ovp_motor_fall", fall[0], 6);
    check("ovp_c5_rise", rise[2], 13);
    check("ovp_c5_fall", fall[2], 17);
    check("ovp_busy_fall", busy_fall, 18);
    check("ovp_overlap", overlap, 0);
    check("ovp_fault", int'(fault), 0);

    // vend_done arriving during the motor drive skips WAIT_DONE.
    clear_rec();
    pulse_in(1'b1, 1'b0, 1'b0);
    watch(12, 2);
    check("early_rise", rise[0], 2);
    check("early_fall", fall[0], 6);
    check("early_busy_fall", busy_fall, 7);
    check("early_fault", int'(fault), 0);

    // Timeout fault, queued refund held until fault_clr.
    clear_rec();
    pulse_in(1'b1, 1'b0, 1'b0);
    watch(1010, -1);
    check("to_motor_rise", rise[0], 2);
    check("to_fault_rise", fault_rise, 1005);
    pulse_in(1'b0, 1'b1, 1'b0);
    clear_rec();
    watch(10, -1);
    check("to_held_qlevel", int'(q_level), 1);
    check("to_held_no_c10", rise[1], -1);
    check("to_held_busy", int'(busy), 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    c0 = cyc;
    check("to_clr_fault", int'(fault), 0);
    clear_rec();
    watch(10, -1);
    check("to_clr_c10_rise", rise[1], 2);
    check("to_clr_qlevel", int'(q_level), 0);

    // Overflow: fill while stalled on fault, then 3 pushes with 1 free slot.
    do_reset();
    clear_rec();
    pulse_in(1'b1, 1'b0, 1'b0);
    watch(1010, -1);
    check("ovf_fault", int'(fault), 1);
    pulse_in(1'b1, 1'b1, 1'b1);
    check("ovf_q3", int'(q_level), 3);
    check("ovf_none_yet", int'(overflow), 0);
    pulse_in(1'b1, 1'b1, 1'b1);
    check("ovf_q4", int'(q_level), 4);
    check("ovf_flag", int'(overflow), 1);
    pulse_in(1'b0, 1'b0, 1'b1);
    check("ovf_q_cap", int'(q_level), 4);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    c0 = cyc;
    check("ovf_clr_ovf", int'(overflow), 0);
    check("ovf_clr_fault", int'(fault), 0);
    clear_rec();
    watch(12, -1);
    check("ovf_motor_rise", rise[0], 2);
    check("ovf_q_after_pop", int'(q_level), 3);

    // Reset mid-drive with two entries left queued.
    do_reset();
    clear_rec();
    pulse_in(1'b1, 1'b1, 1'b1);
    watch(3, -1);
    check("mid_motor_on", int'(vend_motor), 1);
    check("mid_qlevel", int'(q_level), 2);
    rst = 1'b1;
    tick();
    check("mid_rst_motor", int'(vend_motor), 0);
    check("mid_rst_qlevel", int'(q_level), 0);
    check("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    c0 = cyc;
    clear_rec();
    watch(20, -1);
    check("mid_no_motor", rise[0], -1);
    check("mid_no_c10", rise[1], -1);
    check("mid_no_c5", rise[2], -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
